// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, frame constants and baud divider helper
//
// Contents:
//   DATA_BITS      payload bits per frame
//   rx_state_t     receiver FSM states IDLE/START/DATA/STOP
//   tx_state_t     transmitter FSM states TX_IDLE/TX_START/TX_DATA/TX_STOP
//   calc_tick_div  system clocks per sample tick, truncated, never below 1
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int calc_tick_div(input int clk_hz, input int baud, input int oversample);
    int div;
    div = clk_hz / (baud * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - sample tick generator, one clk pulse every TICK_DIV clocks
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   clr   holds the divider at zero; the first tick comes TICK_DIV clocks after release
//   tick  one-clk pulse every TICK_DIV clocks while clr is low
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled, valid/ack byte handshake
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_in      asynchronous serial line, idle high
//   rx_data    last good received byte, LSB received first
//   rx_valid   high while rx_data holds an unacknowledged byte
//   rx_ack     consumer acknowledge, clears rx_valid
//   frame_err  one-clk pulse when the stop bit is sampled low
//   overrun    one-clk pulse when a byte completes over an unacknowledged one
//   busy       high from start-edge detection until the stop-bit sample
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t state, state_next;

  logic                 rx_meta, rxs;
  logic                 tick;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 armed;
  logic                 commit;

  logic start_det, mid_start, data_smp, stop_smp;

  // Two-flop synchroniser; resets to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // Divider is held in IDLE so tick phase is referenced to the detected falling edge.
  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    mid_start  = 1'b0;
    data_smp   = 1'b0;
    stop_smp   = 1'b0;
    case (state)
      IDLE: begin
        // armed is the previous idle-state rxs, so only a fresh 1->0 edge starts a frame
        if (armed && !rxs) begin
          start_det  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (tick && tick_cnt == MID_TICK) begin
          mid_start  = 1'b1;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && tick_cnt == LAST_TICK) begin
          data_smp = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick && tick_cnt == LAST_TICK) begin
          stop_smp   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      commit    <= 1'b0;
    end else begin
      commit <= 1'b0;

      if (state == IDLE) begin
        armed <= rxs;
      end

      if (start_det) begin
        tick_cnt <= '0;
        busy     <= 1'b1;
      end else if (mid_start) begin
        tick_cnt <= '0;
        bit_idx  <= '0;
        if (rxs) begin
          busy <= 1'b0;
        end
      end else if (tick) begin
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + TW'(1);
      end

      if (data_smp) begin
        shift_reg[bit_idx] <= rxs;
        bit_idx            <= (bit_idx == LAST_BIT) ? '0 : bit_idx + BW'(1);
      end

      if (stop_smp) begin
        busy   <= 1'b0;
        commit <= rxs;
      end
    end
  end

  // A committing byte takes priority over a same-cycle ack, which then counts as consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_smp && !rxs;
      overrun   <= commit && rx_valid && !rx_ack;
      if (commit) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with an expected-byte scoreboard
module tb_uart_rx;

  localparam int BIT = 432;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       rx_in  = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_HZ     (50_000_000),
    .BAUD       (115200),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bc, input bit push);
    if (push) exp_q.push_back(b);
    @(posedge clk);
    rx_in = 1'b0;
    repeat (bc) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (bc) @(posedge clk);
    end
    rx_in = stop_bit;
    repeat (bc) @(posedge clk);
  endtask

  task automatic pop_exp(output logic [7:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
  endtask

  task automatic do_ack();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_single();
    int n = 0;
    int fe0;
    logic [7:0] e;
    fe0 = fe_cnt;
    fork
      send_frame(8'h41, 1'b1, BIT, 1'b1);
      begin
        @(posedge clk);
        while (rx_valid !== 1'b1 && n < 6000) begin
          @(negedge clk);
          n++;
        end
      end
    join
    checks++; if (n < 4100 || n > 4120) begin errors++; $display("FAIL single_latency: got %0d clks expected 4100..4120", n); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
    pop_exp(e);
    checks++; if (rx_data !== e) begin errors++; $display("FAIL single_data: got %h expected %h", rx_data, e); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL single_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    do_ack();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    logic [7:0] e;
    int fe0, ov0;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hA5;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(pat[i], 1'b1, BIT, 1'b1);
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, rx_valid); end
      pop_exp(e);
      checks++; if (rx_data !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rx_data, e); end
      do_ack();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected 0", i, rx_valid); end
    end
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL b2b_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_glitch();
    int fe0;
    bit saw_busy = 0;
    fe0 = fe_cnt;
    @(posedge clk);
    rx_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1;
    end
    rx_in = 1'b1;
    for (int i = 0; i < 122; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1;
    end
    checks++; if (!saw_busy) begin errors++; $display("FAIL glitch_busy_seen: got 0 expected 1"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b expected 0", busy); end
    repeat (BIT * 2) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    logic [7:0] e;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, BIT, 1'b0);
    repeat (3000) @(posedge clk);
    rx_in = 1'b1;
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
    send_frame(8'h3C, 1'b1, BIT, 1'b1);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ferr_next_valid: got %b expected 1", rx_valid); end
    pop_exp(e);
    checks++; if (rx_data !== e) begin errors++; $display("FAIL ferr_next_data: got %h expected %h", rx_data, e); end
    do_ack();
  endtask

  task automatic test_overrun();
    int ov0;
    int n = 0;
    logic [7:0] e;
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, BIT, 1'b1);
    send_frame(8'h34, 1'b1, BIT, 1'b1);
    @(negedge clk);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt - ov0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    pop_exp(e);
    pop_exp(e);
    checks++; if (rx_data !== e) begin errors++; $display("FAIL ovr_data: got %h expected %h", rx_data, e); end

    ov0 = ov_cnt;
    fork
      send_frame(8'h56, 1'b1, BIT, 1'b1);
      begin
        @(negedge clk);
        while (busy !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (busy !== 1'b0 && n < 6000) begin @(negedge clk); n++; end
        checks++; if (n >= 6000) begin errors++; $display("FAIL ovr_busy_timeout: got busy=%b expected 0", busy); end
        rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL ovr_coincident: got %0d pulses expected 0", ov_cnt - ov0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_coinc_valid: got %b expected 1", rx_valid); end
    pop_exp(e);
    checks++; if (rx_data !== e) begin errors++; $display("FAIL ovr_coinc_data: got %h expected %h", rx_data, e); end
  endtask

  task automatic test_reset_mid();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'h99, 1'b1, BIT, 1'b0);
      begin
        @(posedge clk);
        repeat (BIT * 5 + BIT / 2) @(posedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_outputs: got data=%h valid=%b busy=%b fe=%b ov=%b expected all 0", rx_data, rx_valid, busy, frame_err, overrun);
        end
      end
    join
    repeat (2) @(posedge clk);
    rst = 1'b0;
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL rstmid_quiet: got valid=%b fe=%0d ov=%0d expected 0 0 0", rx_valid, fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_baud_tol();
    int bcs [3];
    logic [7:0] e;
    bcs[0] = BIT; bcs[1] = 441; bcs[2] = 423;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h7E, 1'b1, bcs[i], 1'b1);
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL tol_valid[%0d]: got %b expected 1", bcs[i], rx_valid); end
      pop_exp(e);
      checks++; if (rx_data !== e) begin errors++; $display("FAIL tol_data[%0d]: got %h expected %h", bcs[i], rx_data, e); end
      do_ack();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_baud_tol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
